id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register with built-in load-use hazard detection for the 5-stage RV32 pipeline. It sits between decode (register file, immediate generator, control decoder) and execute. Each cycle it captures the decoded control signals and operands of the instruction in ID and presents them to EX. When the instruction in ID needs the result of a load still in EX, it raises a stall to PC/IF-ID and inserts a bubble.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- valid_i  in  1  ID slot holds a real instruction
- flush_i  in  1  branch taken; discard the ID instruction
- ALUOp_i  in  2  control: ALU op class (00 ld/st, 01 beq, 10 R, 11 imm)
- ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, Mem2Reg_i, Branch_i  in  1 each  control from decoder
- RS1data_i, RS2data_i  in  32 each  register file read data
- Imm_i  in  32  sign-extended immediate
- funct_i  in  10  {funct7, funct3}
- RS1addr_i, RS2addr_i, RDaddr_i  in  5 each  register indices
- ALUOp_o  out  2  registered ALUOp
- ALUSrc_o, RegWrite_o, MemWrite_o, MemRead_o, Mem2Reg_o, Branch_o  out  1 each  registered control
- RS1data_o, RS2data_o, Imm_o  out  32 each  registered operands
- funct_o  out  10  registered funct
- RS1addr_o, RS2addr_o, RDaddr_o  out  5 each  registered indices
- valid_o  out  1  EX slot holds a real instruction
- stall_o  out  1  combinational; hold PC and IF/ID this cycle
- stall_cnt_o  out  CNT_W  saturating count of stalled cycles

## Operation
- Hazard term: stall_o = valid_i & valid_o & MemRead_o & (RDaddr_o != 0) & ((RDaddr_o == RS1addr_i) | (use_rs2 & (RDaddr_o == RS2addr_i))).
- use_rs2 = ~ALUSrc_i | MemWrite_i. R-type and beq read rs2, and so does sw. addi and lw never stall on an rs2 match.
- stall_o does not depend on flush_i.
- Bubble condition: bubble = stall_o | flush_i | ~valid_i.
- On bubble, next state is: all control outputs 0, ALUOp_o=00, valid_o=0, and all data and address outputs 0.
- Otherwise, every _o register loads its _i counterpart and valid_o=1.
- No hold mode: the register updates every cycle. During a stall, upstream holds the ID instruction, so it is re-presented the next cycle. The hazard then clears because EX now holds the bubble.
- Counter: stall_cnt_o increments on each rising edge where stall_o=1. It saturates at 2^CNT_W-1 and never wraps.
- Simultaneous stall and flush: a bubble is inserted and the counter still increments.

## Timing
- Reset (async, rst_i=1): every registered output is 0 immediately, without waiting for a clock edge. This covers valid_o, stall_cnt_o and all data and control outputs. stall_o=0 follows from valid_o=0.
- Reset mid-stall discards the EX instruction and clears the counter.
- The first capture is the first rising edge after rst_i falls.
- Latency: 1 cycle from _i to _o.
- stall_o is valid in the same cycle as its inputs. Its path is ID inputs and EX registers to the output, with no flop.
- A load-use pair costs exactly one stall cycle. The stall is never asserted for two consecutive cycles for the same pair.

## Test plan
- Reset: drive random inputs with valid_i=1, then pulse rst_i between clock edges -> all outputs read 0 before the next edge; stall_cnt_o=0.
- Pass-through: addi x3,x1,5 (ALUOp 11, ALUSrc 1, RegWrite 1, Imm 5, RS1data 0x10, RD 3) -> next cycle outputs match, valid_o=1, stall_o=0.
- Load-use:
  - Setup: lw x5 captured in EX, then add x6,x5,x1 in ID.
  - Hazard cycle: stall_o=1. Next edge: valid_o=0, all control outputs 0, stall_cnt_o=1.
  - Following edge, with add re-presented: stall_o=0 and add is captured with valid_o=1.
- Non-stall cases, each with lw in EX:
  - lw x0 in EX, add x6,x0,x0 in ID -> stall_o=0.
  - lw x5 in EX, addi x7,x1,0 whose RS2addr field is 5 -> stall_o=0.
  - lw x5 in EX, sw x5,0(x2) in ID -> stall_o=1.
- Flush: flush_i=1 with valid add in ID -> bubble next cycle, stall_cnt_o unchanged. flush_i=1 together with a load-use hazard -> bubble, and the counter increments.
- Saturation: CNT_W=2 with 5 separate load-use stalls -> stall_cnt_o reads 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32 pipeline, with load-use hazard
// detection that stalls PC/IF-ID and injects a bubble into EX.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [1:0]       ALUOp_i,
    input  logic             ALUSrc_i,
    input  logic             RegWrite_i,
    input  logic             MemWrite_i,
    input  logic             MemRead_i,
    input  logic             Mem2Reg_i,
    input  logic             Branch_i,
    input  logic [31:0]      RS1data_i,
    input  logic [31:0]      RS2data_i,
    input  logic [31:0]      Imm_i,
    input  logic [9:0]       funct_i,
    input  logic [4:0]       RS1addr_i,
    input  logic [4:0]       RS2addr_i,
    input  logic [4:0]       RDaddr_i,
    output logic [1:0]       ALUOp_o,
    output logic             ALUSrc_o,
    output logic             RegWrite_o,
    output logic             MemWrite_o,
    output logic             MemRead_o,
    output logic             Mem2Reg_o,
    output logic             Branch_o,
    output logic [31:0]      RS1data_o,
    output logic [31:0]      RS2data_o,
    output logic [31:0]      Imm_o,
    output logic [9:0]       funct_o,
    output logic [4:0]       RS1addr_o,
    output logic [4:0]       RS2addr_o,
    output logic [4:0]       RDaddr_o,
    output logic             valid_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic [1:0]       aluOp_q, aluOp_d;
    logic             aluSrc_q, aluSrc_d;
    logic             regWrite_q, regWrite_d;
    logic             memWrite_q, memWrite_d;
    logic             memRead_q, memRead_d;
    logic             mem2Reg_q, mem2Reg_d;
    logic             branch_q, branch_d;
    logic [31:0]      rs1Data_q, rs1Data_d;
    logic [31:0]      rs2Data_q, rs2Data_d;
    logic [31:0]      imm_q, imm_d;
    logic [9:0]       funct_q, funct_d;
    logic [4:0]       rs1Addr_q, rs1Addr_d;
    logic [4:0]       rs2Addr_q, rs2Addr_d;
    logic [4:0]       rdAddr_q, rdAddr_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

    logic useRs2;
    logic rs1Hit;
    logic rs2Hit;
    logic bubble;

    // Immediate-operand instructions ignore rs2, except stores which need it as data.
    assign useRs2  = ~ALUSrc_i | MemWrite_i;
    assign rs1Hit  = (rdAddr_q == RS1addr_i);
    assign rs2Hit  = (rdAddr_q == RS2addr_i);
    assign stall_o = valid_i & valid_q & memRead_q & (rdAddr_q != 5'd0)
                   & (rs1Hit | (useRs2 & rs2Hit));
    assign bubble  = stall_o | flush_i | ~valid_i;

    always_comb begin
        aluOp_d    = ALUOp_i;
        aluSrc_d   = ALUSrc_i;
        regWrite_d = RegWrite_i;
        memWrite_d = MemWrite_i;
        memRead_d  = MemRead_i;
        mem2Reg_d  = Mem2Reg_i;
        branch_d   = Branch_i;
        rs1Data_d  = RS1data_i;
        rs2Data_d  = RS2data_i;
        imm_d      = Imm_i;
        funct_d    = funct_i;
        rs1Addr_d  = RS1addr_i;
        rs2Addr_d  = RS2addr_i;
        rdAddr_d   = RDaddr_i;
        valid_d    = 1'b1;
        if (bubble) begin
            aluOp_d    = 2'b00;
            aluSrc_d   = 1'b0;
            regWrite_d = 1'b0;
            memWrite_d = 1'b0;
            memRead_d  = 1'b0;
            mem2Reg_d  = 1'b0;
            branch_d   = 1'b0;
            rs1Data_d  = '0;
            rs2Data_d  = '0;
            imm_d      = '0;
            funct_d    = '0;
            rs1Addr_d  = '0;
            rs2Addr_d  = '0;
            rdAddr_d   = '0;
            valid_d    = 1'b0;
        end
    end

    // Saturating so a long-running profile never wraps back to a small value.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stall_o && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aluOp_q    <= 2'b00;
            aluSrc_q   <= 1'b0;
            regWrite_q <= 1'b0;
            memWrite_q <= 1'b0;
            memRead_q  <= 1'b0;
            mem2Reg_q  <= 1'b0;
            branch_q   <= 1'b0;
            rs1Data_q  <= '0;
            rs2Data_q  <= '0;
            imm_q      <= '0;
            funct_q    <= '0;
            rs1Addr_q  <= '0;
            rs2Addr_q  <= '0;
            rdAddr_q   <= '0;
            valid_q    <= 1'b0;
            stallCnt_q <= '0;
        end else begin
            aluOp_q    <= aluOp_d;
            aluSrc_q   <= aluSrc_d;
            regWrite_q <= regWrite_d;
            memWrite_q <= memWrite_d;
            memRead_q  <= memRead_d;
            mem2Reg_q  <= mem2Reg_d;
            branch_q   <= branch_d;
            rs1Data_q  <= rs1Data_d;
            rs2Data_q  <= rs2Data_d;
            imm_q      <= imm_d;
            funct_q    <= funct_d;
            rs1Addr_q  <= rs1Addr_d;
            rs2Addr_q  <= rs2Addr_d;
            rdAddr_q   <= rdAddr_d;
            valid_q    <= valid_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign ALUOp_o     = aluOp_q;
    assign ALUSrc_o    = aluSrc_q;
    assign RegWrite_o  = regWrite_q;
    assign MemWrite_o  = memWrite_q;
    assign MemRead_o   = memRead_q;
    assign Mem2Reg_o   = mem2Reg_q;
    assign Branch_o    = branch_q;
    assign RS1data_o   = rs1Data_q;
    assign RS2data_o   = rs2Data_q;
    assign Imm_o       = imm_q;
    assign funct_o     = funct_q;
    assign RS1addr_o   = rs1Addr_q;
    assign RS2addr_o   = rs2Addr_q;
    assign RDaddr_o    = rdAddr_q;
    assign valid_o     = valid_q;
    assign stall_cnt_o = stallCnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized scoreboard bench for id_ex_stage; a 2-bit-counter instance shares
// the same stimulus so saturation is exercised alongside the default width.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic        flush;
        logic [1:0]  aluOp;
        logic        aluSrc;
        logic        regWrite;
        logic        memWrite;
        logic        memRead;
        logic        mem2Reg;
        logic        branch;
        logic [31:0] rs1Data;
        logic [31:0] rs2Data;
        logic [31:0] imm;
        logic [9:0]  funct;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } instr_t;

    typedef struct packed {
        logic        valid;
        logic [1:0]  aluOp;
        logic        aluSrc;
        logic        regWrite;
        logic        memWrite;
        logic        memRead;
        logic        mem2Reg;
        logic        branch;
        logic [31:0] rs1Data;
        logic [31:0] rs2Data;
        logic [31:0] imm;
        logic [9:0]  funct;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } outs_t;

    typedef struct {
        logic  expStall;
        outs_t expOut;
        int    expCntA;
        int    expCntB;
    } item_t;

    localparam int KIND_LW   = 0;
    localparam int KIND_SW   = 1;
    localparam int KIND_R    = 2;
    localparam int KIND_ADDI = 3;
    localparam int KIND_BEQ  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    instr_t      cur = '0;
    outs_t       outA;
    outs_t       outB;
    logic        stallA;
    logic        stallB;
    logic [15:0] cntA;
    logic [1:0]  cntB;

    item_t sb[$];
    outs_t exModel = '0;
    int    modelCntA = 0;
    int    modelCntB = 0;
    int    checks = 0;
    int    passes = 0;
    logic  monitorOn = 1'b0;

    always #5 clk = ~clk;

    id_ex_stage #(.CNT_W(16)) dutA (
        .clk_i(clk), .rst_i(rst), .valid_i(cur.valid), .flush_i(cur.flush),
        .ALUOp_i(cur.aluOp), .ALUSrc_i(cur.aluSrc), .RegWrite_i(cur.regWrite),
        .MemWrite_i(cur.memWrite), .MemRead_i(cur.memRead), .Mem2Reg_i(cur.mem2Reg),
        .Branch_i(cur.branch), .RS1data_i(cur.rs1Data), .RS2data_i(cur.rs2Data),
        .Imm_i(cur.imm), .funct_i(cur.funct), .RS1addr_i(cur.rs1), .RS2addr_i(cur.rs2),
        .RDaddr_i(cur.rd),
        .ALUOp_o(outA.aluOp), .ALUSrc_o(outA.aluSrc), .RegWrite_o(outA.regWrite),
        .MemWrite_o(outA.memWrite), .MemRead_o(outA.memRead), .Mem2Reg_o(outA.mem2Reg),
        .Branch_o(outA.branch), .RS1data_o(outA.rs1Data), .RS2data_o(outA.rs2Data),
        .Imm_o(outA.imm), .funct_o(outA.funct), .RS1addr_o(outA.rs1), .RS2addr_o(outA.rs2),
        .RDaddr_o(outA.rd), .valid_o(outA.valid), .stall_o(stallA), .stall_cnt_o(cntA)
    );

    id_ex_stage #(.CNT_W(2)) dutB (
        .clk_i(clk), .rst_i(rst), .valid_i(cur.valid), .flush_i(cur.flush),
        .ALUOp_i(cur.aluOp), .ALUSrc_i(cur.aluSrc), .RegWrite_i(cur.regWrite),
        .MemWrite_i(cur.memWrite), .MemRead_i(cur.memRead), .Mem2Reg_i(cur.mem2Reg),
        .Branch_i(cur.branch), .RS1data_i(cur.rs1Data), .RS2data_i(cur.rs2Data),
        .Imm_i(cur.imm), .funct_i(cur.funct), .RS1addr_i(cur.rs1), .RS2addr_i(cur.rs2),
        .RDaddr_i(cur.rd),
        .ALUOp_o(outB.aluOp), .ALUSrc_o(outB.aluSrc), .RegWrite_o(outB.regWrite),
        .MemWrite_o(outB.memWrite), .MemRead_o(outB.memRead), .Mem2Reg_o(outB.mem2Reg),
        .Branch_o(outB.branch), .RS1data_o(outB.rs1Data), .RS2data_o(outB.rs2Data),
        .Imm_o(outB.imm), .funct_o(outB.funct), .RS1addr_o(outB.rs1), .RS2addr_o(outB.rs2),
        .RDaddr_o(outB.rd), .valid_o(outB.valid), .stall_o(stallB), .stall_cnt_o(cntB)
    );

    task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Builds a well-formed RV32 instruction of the given class with random operand data.
    function automatic instr_t mkInstr(input int kind, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [31:0] imm);
        instr_t t = '0;
        t.valid   = 1'b1;
        t.rd      = rd;
        t.rs1     = rs1;
        t.rs2     = rs2;
        t.imm     = imm;
        t.rs1Data = $urandom;
        t.rs2Data = $urandom;
        t.funct   = 10'($urandom);
        case (kind)
            KIND_LW:   begin t.aluOp = 2'b00; t.aluSrc = 1'b1; t.regWrite = 1'b1; t.memRead = 1'b1; t.mem2Reg = 1'b1; end
            KIND_SW:   begin t.aluOp = 2'b00; t.aluSrc = 1'b1; t.memWrite = 1'b1; end
            KIND_R:    begin t.aluOp = 2'b10; t.aluSrc = 1'b0; t.regWrite = 1'b1; end
            KIND_ADDI: begin t.aluOp = 2'b11; t.aluSrc = 1'b1; t.regWrite = 1'b1; end
            default:   begin t.aluOp = 2'b01; t.aluSrc = 1'b0; t.branch = 1'b1; end
        endcase
        return t;
    endfunction

    function automatic outs_t toOuts(input instr_t t);
        outs_t o;
        o.valid    = 1'b1;
        o.aluOp    = t.aluOp;
        o.aluSrc   = t.aluSrc;
        o.regWrite = t.regWrite;
        o.memWrite = t.memWrite;
        o.memRead  = t.memRead;
        o.mem2Reg  = t.mem2Reg;
        o.branch   = t.branch;
        o.rs1Data  = t.rs1Data;
        o.rs2Data  = t.rs2Data;
        o.imm      = t.imm;
        o.funct    = t.funct;
        o.rs1      = t.rs1;
        o.rs2      = t.rs2;
        o.rd       = t.rd;
        return o;
    endfunction

    // Reference: an instruction must wait if EX holds a load whose destination
    // is a register this instruction actually reads.
    function automatic logic mustWait(input instr_t t, input outs_t ex);
        logic readsRs2;
        readsRs2 = (t.aluOp == 2'b10) || (t.aluOp == 2'b01) || t.memWrite;
        if (!t.valid || !ex.valid || !ex.memRead || ex.rd == 5'd0) return 1'b0;
        return (ex.rd == t.rs1) || (readsRs2 && ex.rd == t.rs2);
    endfunction

    task automatic applyStimulus(input instr_t t, output logic stalled);
        item_t it;
        @(negedge clk);
        cur = t;
        stalled = mustWait(t, exModel);
        if (stalled) begin
            if (modelCntA < 65535) modelCntA++;
            if (modelCntB < 3) modelCntB++;
        end
        exModel = (stalled || t.flush || !t.valid) ? outs_t'('0) : toOuts(t);
        it.expStall = stalled;
        it.expOut   = exModel;
        it.expCntA  = modelCntA;
        it.expCntB  = modelCntB;
        sb.push_back(it);
    endtask

    // Upstream holds a stalled instruction and re-presents it next cycle.
    task automatic issue(input instr_t t);
        logic s;
        applyStimulus(t, s);
        if (s && !t.flush) applyStimulus(t, s);
    endtask

    initial begin : monitor
        item_t it;
        wait (monitorOn);
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                checkOutput("stall_o", stallA, sb[0].expStall);
                checkOutput("stall_o_cnt2", stallB, sb[0].expStall);
            end
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                it = sb.pop_front();
                checkOutput("ex_regs", outA, it.expOut);
                checkOutput("ex_regs_cnt2", outB, it.expOut);
                checkOutput("stall_cnt", cntA, it.expCntA);
                checkOutput("stall_cnt_sat", cntB, it.expCntB);
            end
        end
    end

    initial begin : stimulus
        instr_t t;
        instr_t lw5;
        instr_t add6;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        repeat (3) begin
            @(negedge clk);
            cur = mkInstr($urandom_range(0, 4), 5'($urandom_range(1, 31)),
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("reset_regs", outA, '0);
        checkOutput("reset_regs_cnt2", outB, '0);
        checkOutput("reset_stall", stallA, 1'b0);
        checkOutput("reset_cnt", cntA, 16'd0);
        #1 rst = 1'b0;

        lw5  = mkInstr(KIND_LW, 5'd5, 5'd2, 5'd0, 32'd0);
        add6 = mkInstr(KIND_R, 5'd6, 5'd5, 5'd1, 32'd0);
        @(negedge clk) cur = lw5;
        @(negedge clk) cur = add6;
        #1 checkOutput("midstall_stall", stallA, 1'b1);
        @(posedge clk);
        #1 checkOutput("midstall_cnt", cntA, 16'd1);
        @(negedge clk) cur = lw5;
        @(negedge clk) cur = add6;
        #1 checkOutput("midstall_stall2", stallA, 1'b1);
        #1 rst = 1'b1;
        #1;
        checkOutput("midstall_reset_valid", outA.valid, 1'b0);
        checkOutput("midstall_reset_stall", stallA, 1'b0);
        checkOutput("midstall_reset_cnt", cntA, 16'd0);
        checkOutput("midstall_reset_cnt2", cntB, 2'd0);
        cur = '0;
        @(negedge clk) rst = 1'b0;
        exModel   = '0;
        modelCntA = 0;
        modelCntB = 0;
        monitorOn = 1'b1;

        t = mkInstr(KIND_ADDI, 5'd3, 5'd1, 5'd0, 32'd5);
        t.rs1Data = 32'h10;
        issue(t);
        issue(mkInstr(KIND_LW, 5'd5, 5'd2, 5'd0, 32'd4));
        issue(mkInstr(KIND_R, 5'd6, 5'd5, 5'd1, 32'd0));
        issue(mkInstr(KIND_LW, 5'd0, 5'd2, 5'd0, 32'd8));
        issue(mkInstr(KIND_R, 5'd6, 5'd0, 5'd0, 32'd0));
        issue(mkInstr(KIND_LW, 5'd5, 5'd2, 5'd0, 32'd4));
        issue(mkInstr(KIND_ADDI, 5'd7, 5'd1, 5'd5, 32'd0));
        issue(mkInstr(KIND_LW, 5'd5, 5'd2, 5'd0, 32'd4));
        issue(mkInstr(KIND_SW, 5'd0, 5'd2, 5'd5, 32'd0));
        t = mkInstr(KIND_R, 5'd6, 5'd1, 5'd2, 32'd0);
        t.flush = 1'b1;
        issue(t);
        issue(mkInstr(KIND_LW, 5'd5, 5'd2, 5'd0, 32'd4));
        t = mkInstr(KIND_R, 5'd6, 5'd5, 5'd1, 32'd0);
        t.flush = 1'b1;
        issue(t);
        repeat (5) begin
            issue(mkInstr(KIND_LW, 5'd5, 5'd2, 5'd0, 32'd4));
            issue(mkInstr(KIND_R, 5'd6, 5'd5, 5'd1, 32'd0));
        end

        repeat (400) begin
            t = mkInstr($urandom_range(0, 4), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom);
            t.valid = ($urandom_range(0, 9) != 0);
            t.flush = ($urandom_range(0, 9) == 0);
            issue(t);
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
